// File: rtl/traffic_fsm.sv
// Two-road traffic-light phase controller.
// Steps NS/WE through green, yellow and red on a prescaled tick, and publishes
// per-direction BCD countdowns plus the phase code for the segment display driver.
module traffic_fsm #(
    parameter int TICK_DIV = 50000000,
    parameter int GREEN_S  = 25,
    parameter int YELLOW_S = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    output logic [2:0]  out_LED3_NS,
    output logic [2:0]  out_LED3_WE,
    output logic [15:0] data,
    output logic [1:0]  Stage
);

    typedef enum logic [1:0] {
        ST_NS_GREEN  = 2'd0,
        ST_NS_YELLOW = 2'd1,
        ST_WE_GREEN  = 2'd2,
        ST_WE_YELLOW = 2'd3
    } stage_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);
    localparam logic [6:0]    GREEN_C   = 7'(GREEN_S);
    localparam logic [6:0]    YELLOW_C  = 7'(YELLOW_S);

    localparam logic [2:0] LED_GREEN  = 3'b001;
    localparam logic [2:0] LED_YELLOW = 3'b010;
    localparam logic [2:0] LED_RED    = 3'b100;

    // Binary 0..99 to packed BCD {tens, units} by repeated subtraction of ten.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] tens;
        logic [6:0] rem;
        tens = 4'd0;
        rem  = v;
        for (int i = 0; i < 9; i++) begin
            if (rem >= 7'd10) begin
                rem  = rem - 7'd10;
                tens = tens + 4'd1;
            end else begin
                rem  = rem;
            end
        end
        return {tens, rem[3:0]};
    endfunction

    localparam logic [15:0] RESET_DATA = {to_bcd(GREEN_C), to_bcd(GREEN_C + YELLOW_C)};

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [6:0]    cnt_q, cnt_d;
    stage_t        stage_q, stage_d;
    logic          tick_s;
    logic [6:0]    ns_val_s, we_val_s;
    logic [2:0]    led_ns_s, led_we_s;

    // Hold freezes the prescaler, so a tick can only fire while running.
    assign tick_s = (hold == 1'b0) && (pcnt_q == PCNT_LAST);

    // Next-state logic for prescaler, countdown and phase sequencing.
    always_comb begin
        pcnt_d  = pcnt_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        if (hold) begin
            pcnt_d = pcnt_q;
        end else if (tick_s) begin
            pcnt_d = '0;
            if (cnt_q > 7'd1) begin
                cnt_d = cnt_q - 7'd1;
            end else begin
                case (stage_q)
                    ST_NS_GREEN:  begin stage_d = ST_NS_YELLOW; cnt_d = YELLOW_C; end
                    ST_NS_YELLOW: begin stage_d = ST_WE_GREEN;  cnt_d = GREEN_C;  end
                    ST_WE_GREEN:  begin stage_d = ST_WE_YELLOW; cnt_d = YELLOW_C; end
                    ST_WE_YELLOW: begin stage_d = ST_NS_GREEN;  cnt_d = GREEN_C;  end
                    default:      begin stage_d = ST_NS_GREEN;  cnt_d = GREEN_C;  end
                endcase
            end
        end else begin
            pcnt_d = pcnt_q + PW'(1);
        end
    end

    // Lamp pattern and displayed countdowns; the red side counts to its own green.
    always_comb begin
        ns_val_s = cnt_q;
        we_val_s = cnt_q;
        led_ns_s = LED_RED;
        led_we_s = LED_RED;
        case (stage_q)
            ST_NS_GREEN: begin
                ns_val_s = cnt_q;
                we_val_s = cnt_q + YELLOW_C;
                led_ns_s = LED_GREEN;
                led_we_s = LED_RED;
            end
            ST_NS_YELLOW: begin
                led_ns_s = LED_YELLOW;
                led_we_s = LED_RED;
            end
            ST_WE_GREEN: begin
                ns_val_s = cnt_q + YELLOW_C;
                we_val_s = cnt_q;
                led_ns_s = LED_RED;
                led_we_s = LED_GREEN;
            end
            ST_WE_YELLOW: begin
                led_ns_s = LED_RED;
                led_we_s = LED_YELLOW;
            end
            default: begin
                led_ns_s = LED_RED;
                led_we_s = LED_RED;
            end
        endcase
    end

    // State update plus registered outputs (one-cycle lag behind the state).
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q      <= '0;
            cnt_q       <= GREEN_C;
            stage_q     <= ST_NS_GREEN;
            out_LED3_NS <= LED_GREEN;
            out_LED3_WE <= LED_RED;
            data        <= RESET_DATA;
            Stage       <= 2'd0;
        end else begin
            pcnt_q      <= pcnt_d;
            cnt_q       <= cnt_d;
            stage_q     <= stage_d;
            out_LED3_NS <= led_ns_s;
            out_LED3_WE <= led_we_s;
            data        <= {to_bcd(ns_val_s), to_bcd(we_val_s)};
            Stage       <= stage_q;
        end
    end

endmodule

// File: tb/tb_traffic_fsm.sv
// Directed bench for traffic_fsm: small-parameter instance for sequencing,
// hold and reset behaviour; default-duration instance for BCD and phase length.
module tb_traffic_fsm;

    logic        clk;
    logic        rst_a, hold_a, rst_b, hold_b;
    logic [2:0]  ns_a, we_a, ns_b, we_b;
    logic [15:0] data_a, data_b;
    logic [1:0]  stage_a, stage_b;

    int n_checks;
    int n_fail;

    logic [15:0] exp_data  [10];
    logic [1:0]  exp_stage [10];
    logic [2:0]  led_ns_of [4];
    logic [2:0]  led_we_of [4];

    traffic_fsm #(.TICK_DIV(4), .GREEN_S(3), .YELLOW_S(2)) dut_a (
        .clk(clk), .rst(rst_a), .hold(hold_a),
        .out_LED3_NS(ns_a), .out_LED3_WE(we_a), .data(data_a), .Stage(stage_a)
    );

    traffic_fsm #(.TICK_DIV(2)) dut_b (
        .clk(clk), .rst(rst_b), .hold(hold_b),
        .out_LED3_NS(ns_b), .out_LED3_WE(we_b), .data(data_b), .Stage(stage_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [15:0] d, input logic [1:0] s);
        chk({tag, "_data"}, 32'(data_a), 32'(d));
        chk({tag, "_stage"}, 32'(stage_a), 32'(s));
        chk({tag, "_ns"}, 32'(ns_a), 32'(led_ns_of[s]));
        chk({tag, "_we"}, 32'(we_a), 32'(led_we_of[s]));
    endtask

    initial begin
        int idx;
        n_checks = 0;
        n_fail   = 0;
        exp_data  = '{16'h0305, 16'h0204, 16'h0103, 16'h0202, 16'h0101,
                      16'h0503, 16'h0402, 16'h0301, 16'h0202, 16'h0101};
        exp_stage = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3};
        led_ns_of = '{3'b001, 3'b010, 3'b100, 3'b100};
        led_we_of = '{3'b100, 3'b100, 3'b001, 3'b010};

        rst_a = 1'b1; hold_a = 1'b0;
        rst_b = 1'b1; hold_b = 1'b0;
        #2;
        step();
        chk_a("a_reset", 16'h0305, 2'd0);
        rst_a = 1'b0;

        // Three full cycles of 40 clocks: sequence table and lamp invariants.
        for (int n = 1; n <= 120; n++) begin
            step();
            idx = ((n - 1) / 4) % 10;
            chk_a("a_run", exp_data[idx], exp_stage[idx]);
            chk("a_ns_onehot", 32'($onehot(ns_a)), 32'd1);
            chk("a_we_onehot", 32'($onehot(we_a)), 32'd1);
            chk("a_both_nonred", 32'((ns_a != 3'b100) && (we_a != 3'b100)), 32'd0);
        end

        // Hold across a would-be tick in phase 2.
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        for (int n = 1; n <= 23; n++) step();
        chk_a("a_pre_hold", 16'h0503, 2'd2);
        hold_a = 1'b1;
        for (int n = 24; n <= 33; n++) begin
            step();
            chk_a("a_hold", 16'h0503, 2'd2);
        end
        hold_a = 1'b0;
        step();
        chk_a("a_release_tick", 16'h0503, 2'd2);
        step();
        chk_a("a_after_release", 16'h0402, 2'd2);

        // Reset during phase 3 while held.
        for (int n = 36; n <= 45; n++) step();
        chk_a("a_phase3", 16'h0202, 2'd3);
        hold_a = 1'b1;
        rst_a  = 1'b1;
        step();
        chk_a("a_rst_hold", 16'h0305, 2'd0);
        rst_a = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            step();
            chk_a("a_held_reset", 16'h0305, 2'd0);
        end
        hold_a = 1'b0;
        for (int n = 1; n <= 4; n++) step();
        chk_a("a_restart_pre", 16'h0305, 2'd0);
        step();
        chk_a("a_restart_tick", 16'h0204, 2'd0);

        // Default durations with a fast tick.
        chk("b_reset_data", 32'(data_b), 32'h2530);
        chk("b_reset_ns", 32'(ns_b), 32'(3'b001));
        chk("b_reset_we", 32'(we_b), 32'(3'b100));
        chk("b_reset_stage", 32'(stage_b), 32'd0);
        rst_b = 1'b0;
        for (int n = 1; n <= 51; n++) begin
            step();
            if (n == 12) chk("b_tens_20", 32'(data_b), 32'h2025);
            if (n == 13) chk("b_tens_19", 32'(data_b), 32'h1924);
            if (n == 50) begin
                chk("b_last_green_data", 32'(data_b), 32'h0106);
                chk("b_last_green_stage", 32'(stage_b), 32'd0);
            end
            if (n == 51) begin
                chk("b_yellow_data", 32'(data_b), 32'h0505);
                chk("b_yellow_stage", 32'(stage_b), 32'd1);
                chk("b_yellow_ns", 32'(ns_b), 32'(3'b010));
                chk("b_yellow_we", 32'(we_b), 32'(3'b100));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
